// File: rtl/systolic_mm_engine_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: FSM encoding,
// derived-width helpers and the drain-length function.
package systolic_mm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int unsigned kl_bits(input int unsigned k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int unsigned o_bits(input int unsigned i_bits, input int unsigned k_max);
    return 2 * i_bits + $clog2(k_max);
  endfunction

  // Cycles for the last operand pair to reach the far corner PE.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Job control, operand beat stream and result bus of the systolic engine.
interface systolic_mm_engine_if
  import systolic_mm_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned I_BITS  = 8,
  parameter int unsigned K_MAX   = 16,
  parameter int unsigned KL_BITS = kl_bits(K_MAX),
  parameter int unsigned O_BITS  = o_bits(I_BITS, K_MAX)
);

  logic                          i_start;
  logic [KL_BITS-1:0]            i_k_len;
  logic                          i_signed;
  logic                          i_accum;
  logic                          i_valid;
  logic                          o_ready;
  logic [ROWS*I_BITS-1:0]        i_a_col;
  logic [COLS*I_BITS-1:0]        i_b_row;
  logic                          o_busy;
  logic                          o_done;
  logic [ROWS*COLS*O_BITS-1:0]   o_c_full;

  modport master (
    output i_start, i_k_len, i_signed, i_accum, i_valid, i_a_col, i_b_row,
    input  o_ready, o_busy, o_done, o_c_full
  );

  modport slave (
    input  i_start, i_k_len, i_signed, i_accum, i_valid, i_a_col, i_b_row,
    output o_ready, o_busy, o_done, o_c_full
  );

endinterface

// File: rtl/systolic_mm_engine_mac_pe.sv
// One processing element: forwards a right and b down with their valid tags
// and accumulates the product when both tags are set.
module systolic_mac_pe
  import systolic_mm_pkg::*;
#(
  parameter int unsigned I_BITS = 8,
  parameter int unsigned O_BITS = 20
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              signed_mode,
  input  logic              clear,
  input  logic [I_BITS-1:0] a,
  input  logic              a_v,
  input  logic [I_BITS-1:0] b,
  input  logic              b_v,
  output logic [I_BITS-1:0] a_pass,
  output logic              a_pass_v,
  output logic [I_BITS-1:0] b_pass,
  output logic              b_pass_v,
  output logic [O_BITS-1:0] acc
);

  // Sign/zero extension to full width makes the truncated product correct in both modes.
  function automatic logic [O_BITS-1:0] ext(input logic [I_BITS-1:0] x, input logic s);
    return s ? {{(O_BITS-I_BITS){x[I_BITS-1]}}, x} : {{(O_BITS-I_BITS){1'b0}}, x};
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      a_pass   <= '0;
      a_pass_v <= 1'b0;
      b_pass   <= '0;
      b_pass_v <= 1'b0;
      acc      <= '0;
    end else begin
      a_pass   <= a;
      a_pass_v <= a_v;
      b_pass   <= b;
      b_pass_v <= b_v;
      if (clear)
        acc <= '0;
      else if (a_v && b_v)
        acc <= acc + ext(a, signed_mode) * ext(b, signed_mode);
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Valid/ready systolic matrix multiplier: job FSM, input skew chains and a
// ROWS x COLS mesh of MAC PEs whose accumulators form the result bus.
module systolic_mm_engine
  import systolic_mm_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLS    = 4,
  parameter int unsigned I_BITS  = 8,
  parameter int unsigned K_MAX   = 16,
  parameter int unsigned KL_BITS = kl_bits(K_MAX),
  parameter int unsigned O_BITS  = o_bits(I_BITS, K_MAX)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  systolic_mm_engine_if.slave  bus
);

  localparam int unsigned DC_BITS = (ROWS + COLS > 1) ? $clog2(ROWS + COLS) : 1;

  logic [1:0]         state, state_nxt;
  logic [KL_BITS-1:0] k_q, k_nxt, beat_cnt, beat_nxt, k_clamped;
  logic [DC_BITS-1:0] drain_cnt, drain_nxt;
  logic               signed_q, signed_nxt;
  logic               clear_c;
  logic               ready_q, busy_q, done_q;
  logic               accept;

  assign accept    = bus.i_valid & ready_q;
  assign k_clamped = (bus.i_k_len > KL_BITS'(K_MAX)) ? KL_BITS'(K_MAX) : bus.i_k_len;

  // Next-state and job-parameter logic.
  always_comb begin
    state_nxt  = state;
    k_nxt      = k_q;
    beat_nxt   = beat_cnt;
    drain_nxt  = drain_cnt;
    signed_nxt = signed_q;
    clear_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          k_nxt      = k_clamped;
          signed_nxt = bus.i_signed;
          beat_nxt   = '0;
          clear_c    = ~bus.i_accum;
          state_nxt  = (k_clamped == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          beat_nxt = beat_cnt + KL_BITS'(1);
          if (beat_cnt == k_q - KL_BITS'(1)) begin
            state_nxt = ST_DRAIN;
            drain_nxt = DC_BITS'(drain_len(ROWS, COLS));
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0)
          state_nxt = ST_DONE;
        else
          drain_nxt = drain_cnt - DC_BITS'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The extra registered stage on done makes it land ROWS+COLS edges after the final beat.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      signed_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      k_q       <= k_nxt;
      beat_cnt  <= beat_nxt;
      drain_cnt <= drain_nxt;
      signed_q  <= signed_nxt;
      ready_q   <= (state_nxt == ST_LOAD);
      busy_q    <= (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN);
      done_q    <= (state == ST_DONE);
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

  logic [I_BITS-1:0] a_h  [ROWS][COLS+1];
  logic              av_h [ROWS][COLS+1];
  logic [I_BITS-1:0] b_v  [ROWS+1][COLS];
  logic              bv_v [ROWS+1][COLS];
  logic [O_BITS-1:0] acc_w [ROWS*COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_h[0][0]  = bus.i_a_col[0 +: I_BITS];
      assign av_h[0][0] = accept;
    end else begin : g_delay
      logic [I_BITS-1:0] d  [r];
      logic              dv [r];
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          for (int i = 0; i < r; i++) begin
            d[i]  <= '0;
            dv[i] <= 1'b0;
          end
        end else begin
          d[0]  <= bus.i_a_col[r*I_BITS +: I_BITS];
          dv[0] <= accept;
          for (int i = 1; i < r; i++) begin
            d[i]  <= d[i-1];
            dv[i] <= dv[i-1];
          end
        end
      end
      assign a_h[r][0]  = d[r-1];
      assign av_h[r][0] = dv[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign b_v[0][0]  = bus.i_b_row[0 +: I_BITS];
      assign bv_v[0][0] = accept;
    end else begin : g_delay
      logic [I_BITS-1:0] d  [c];
      logic              dv [c];
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          for (int i = 0; i < c; i++) begin
            d[i]  <= '0;
            dv[i] <= 1'b0;
          end
        end else begin
          d[0]  <= bus.i_b_row[c*I_BITS +: I_BITS];
          dv[0] <= accept;
          for (int i = 1; i < c; i++) begin
            d[i]  <= d[i-1];
            dv[i] <= dv[i-1];
          end
        end
      end
      assign b_v[0][c]  = d[c-1];
      assign bv_v[0][c] = dv[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_mac_pe #(
        .I_BITS (I_BITS),
        .O_BITS (O_BITS)
      ) u_pe (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .signed_mode (signed_q),
        .clear       (clear_c),
        .a           (a_h[r][c]),
        .a_v         (av_h[r][c]),
        .b           (b_v[r][c]),
        .b_v         (bv_v[r][c]),
        .a_pass      (a_h[r][c+1]),
        .a_pass_v    (av_h[r][c+1]),
        .b_pass      (b_v[r+1][c]),
        .b_pass_v    (bv_v[r+1][c]),
        .acc         (acc_w[r*COLS+c])
      );
    end
  end

  logic [ROWS*COLS*O_BITS-1:0] c_full_w;
  always_comb begin
    c_full_w = '0;
    for (int i = 0; i < ROWS*COLS; i++)
      c_full_w[i*O_BITS +: O_BITS] = acc_w[i];
  end
  assign bus.o_c_full = c_full_w;

  // Operands leaving the right and bottom edges of the mesh are discarded.
  logic unused_tail;
  always_comb begin
    unused_tail = 1'b0;
    for (int r = 0; r < ROWS; r++)
      unused_tail = unused_tail ^ (^a_h[r][COLS]) ^ av_h[r][COLS];
    for (int c = 0; c < COLS; c++)
      unused_tail = unused_tail ^ (^b_v[ROWS][c]) ^ bv_v[ROWS][c];
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine with hand-computed expected results.
module tb_systolic_mm_engine;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int OB   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_mm_engine_if bus ();

  systolic_mm_engine dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  int last_cyc = 0;
  int busy_low = 0;
  logic [31:0] a_beats [16];
  logic [31:0] b_beats [16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.i_valid && bus.o_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OB-1:0] c_at(input int r, input int c);
    return bus.o_c_full[(r*COLS+c)*OB +: OB];
  endfunction

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    for (int k = 0; k < 16; k++) begin
      a_beats[k] = {4{av}};
      b_beats[k] = {4{bv}};
    end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 4; i++) begin
        a_beats[k][i*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
        b_beats[k][i*8 +: 8] = 8'(4*k + i + 1);
      end
  endtask

  task automatic start_job(input int kl, input bit sgn, input bit accm);
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_k_len  = 5'(kl);
    bus.i_signed = sgn;
    bus.i_accum  = accm;
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
  endtask

  task automatic feed(input int n, input bit bubbles);
    int k = 0;
    int guard = 0;
    bit ph = 1'b1;
    bit take;
    busy_low = 0;
    while (k < n && guard < 200) begin
      bus.i_valid = bubbles ? ph : 1'b1;
      bus.i_a_col = a_beats[k];
      bus.i_b_row = b_beats[k];
      take = bus.i_valid && bus.o_ready;
      @(posedge clk); #1;
      if (take) begin
        k++;
        last_cyc = cyc;
      end
      if (!bus.o_busy) busy_low++;
      ph = ~ph;
      guard++;
    end
    bus.i_valid = 1'b0;
    chk("beats_fed", 64'(k), 64'(n));
  endtask

  task automatic wait_done(input int exp_lat, input bit chk_lat);
    int w = 0;
    while (!bus.o_done && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_seen", 64'(bus.o_done), 64'd1);
    if (chk_lat) chk("done_lat", 64'(cyc - last_cyc), 64'(exp_lat));
    @(posedge clk); #1;
    chk("done_pulse", 64'(bus.o_done), 64'd0);
  endtask

  task automatic check_all(input string tag, input logic [OB-1:0] exp);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk(tag, 64'(c_at(r, c)), 64'(exp));
  endtask

  task automatic check_identity(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk(tag, 64'(c_at(r, c)), 64'(4*r + c + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int seen;
    bus.i_start  = 1'b0;
    bus.i_k_len  = '0;
    bus.i_signed = 1'b0;
    bus.i_accum  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_a_col  = '0;
    bus.i_b_row  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_busy",  64'(bus.o_busy),  64'd0);
    chk("rst_done",  64'(bus.o_done),  64'd0);
    chk("rst_c",     64'(|bus.o_c_full), 64'd0);
    rst = 1'b0;

    // Identity: A = I gives C = B
    fill_identity();
    start_job(4, 1'b0, 1'b0);
    chk("load_ready", 64'(bus.o_ready), 64'd1);
    feed(4, 1'b0);
    chk("id_busy", 64'(busy_low), 64'd0);
    wait_done(8, 1'b1);
    check_identity("id_c");

    // Bubbles between beats
    start_job(4, 1'b0, 1'b0);
    feed(4, 1'b1);
    chk("bub_busy", 64'(busy_low), 64'd0);
    wait_done(8, 1'b1);
    check_identity("bub_c");

    // Signed/unsigned extremes
    fill_const(8'h80, 8'h80);
    start_job(16, 1'b1, 1'b0);
    feed(16, 1'b0);
    wait_done(8, 1'b1);
    check_all("s80_c", 20'h40000);
    start_job(16, 1'b0, 1'b0);
    feed(16, 1'b0);
    wait_done(8, 1'b1);
    check_all("u80_c", 20'h40000);
    fill_const(8'hFF, 8'h02);
    start_job(16, 1'b1, 1'b0);
    feed(16, 1'b0);
    wait_done(8, 1'b1);
    check_all("sff_c", 20'hFFFE0);
    start_job(16, 1'b0, 1'b0);
    feed(16, 1'b0);
    wait_done(8, 1'b1);
    check_all("uff_c", 20'd8160);

    // Accumulate then clear
    fill_const(8'h01, 8'h01);
    start_job(2, 1'b0, 1'b0);
    feed(2, 1'b0);
    wait_done(8, 1'b1);
    check_all("acc1_c", 20'd2);
    start_job(2, 1'b0, 1'b1);
    feed(2, 1'b0);
    wait_done(8, 1'b1);
    check_all("acc2_c", 20'd4);
    start_job(2, 1'b0, 1'b0);
    feed(2, 1'b0);
    wait_done(8, 1'b1);
    check_all("acc3_c", 20'd2);

    // K = 0: no beats, done straight away, accumulators cleared
    base = acc_cnt;
    bus.i_valid = 1'b1;
    start_job(0, 1'b0, 1'b0);
    chk("k0_early", 64'(bus.o_done), 64'd0);
    @(posedge clk); #1;
    chk("k0_done", 64'(bus.o_done), 64'd1);
    @(posedge clk); #1;
    chk("k0_pulse", 64'(bus.o_done), 64'd0);
    bus.i_valid = 1'b0;
    chk("k0_beats", 64'(acc_cnt - base), 64'd0);
    check_all("k0_c", 20'd0);

    // K clamped to K_MAX
    fill_const(8'h01, 8'h01);
    bus.i_a_col = a_beats[0];
    bus.i_b_row = b_beats[0];
    base = acc_cnt;
    start_job(31, 1'b0, 1'b0);
    bus.i_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("k31_beats", 64'(acc_cnt - base), 64'd16);
    wait_done(0, 1'b0);
    chk("k31_c00", 64'(c_at(0, 0)), 64'd16);
    chk("k31_c33", 64'(c_at(3, 3)), 64'd16);

    // Abort mid-job
    start_job(8, 1'b0, 1'b0);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.o_ready), 64'd0);
    chk("abort_busy",  64'(bus.o_busy),  64'd0);
    chk("abort_done",  64'(bus.o_done),  64'd0);
    chk("abort_c",     64'(|bus.o_c_full), 64'd0);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.o_done) seen++;
    end
    chk("abort_nodone", 64'(seen), 64'd0);
    chk("abort_c_hold", 64'(|bus.o_c_full), 64'd0);

    fill_identity();
    start_job(4, 1'b0, 1'b0);
    feed(4, 1'b0);
    wait_done(8, 1'b1);
    check_identity("post_c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
